traffic_status_monitor: RTL

- Consumer-side counterpart of the four-lane countdown/LED generator. Samples count1..count4 and led1..led4, drives a 4-digit multiplexed seven-segment display (one hex digit per lane, decimal point = lane green), and checks the generator's output protocol.
- Reports the active lane, counts green hand-offs and raises sticky fault flags for one-hot and countdown-step violations.
- Sits between the generator and the board display/status LEDs.

---
 rtl/traffic_status_monitor.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/traffic_status_monitor.sv
// rtl/traffic_status_monitor.sv - four-lane countdown/LED consumer: seven-segment scan plus protocol checks
//
// Purpose: samples the four-lane generator outputs, drives a multiplexed
// 4-digit seven-segment display (one hex digit per lane, decimal point marks
// the green lane), reports the active lane, counts green hand-offs and raises
// sticky faults for one-hot and countdown-step violations.
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-low reset
//   count1..count4   lane countdown values
//   led1..led4       lane green indicators
//   clr              clears fault flags, glitch counter and handoff_cnt
//   seg[6:0]         segments {g,f,e,d,c,b,a}, active-high
//   dp               decimal point (green of the displayed lane)
//   an[3:0]          digit enables, active-low, bit i = lane i+1
//   active_lane[1:0] index of the green lane (holds while not one-hot)
//   active_vld       led vector currently one-hot
//   handoff_cnt[7:0] green hand-offs, saturating at 255
//   onehot_err       sticky one-hot fault
//   step_err         sticky countdown-step fault

module traffic_status_monitor #(
    parameter int SCAN_DIV   = 4,
    parameter int GLITCH_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count1,
    input  logic [3:0] count2,
    input  logic [3:0] count3,
    input  logic [3:0] count4,
    input  logic       led1,
    input  logic       led2,
    input  logic       led3,
    input  logic       led4,
    input  logic       clr,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic [1:0] active_lane,
    output logic       active_vld,
    output logic [7:0] handoff_cnt,
    output logic       onehot_err,
    output logic       step_err
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int GW = $clog2(GLITCH_CYC + 1);

    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [GW-1:0] GLITCH_MAX = GW'(GLITCH_CYC);

    // Sample (S) and previous-sample (P) stages
    logic [3:0]    s_cnt [4];
    logic [3:0]    p_cnt [4];
    logic [3:0]    s_led;
    logic [3:0]    p_led;
    logic          prev_vld;

    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit;
    logic [GW-1:0] glitch_cnt;

    logic          s_onehot;
    logic          p_onehot;
    logic          handoff_hit;
    logic          step_hit;
    logic [GW-1:0] glitch_nxt;
    logic [1:0]    s_lane;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        is_onehot = (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    always_comb begin
        s_onehot = is_onehot(s_led);
        p_onehot = is_onehot(p_led);

        s_lane = 2'd0;
        case (s_led)
            4'b0010: s_lane = 2'd1;
            4'b0100: s_lane = 2'd2;
            4'b1000: s_lane = 2'd3;
            default: s_lane = 2'd0;
        endcase

        handoff_hit = prev_vld && s_onehot && p_onehot && (s_led != p_led);

        // Only a lane that stayed green across both samples is checked; a lane
        // going red may be reloaded with anything.
        step_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (prev_vld && s_led[i] && p_led[i]) begin
                if (!((s_cnt[i] == p_cnt[i]) ||
                      ((p_cnt[i] != 4'd0) && (s_cnt[i] == p_cnt[i] - 4'd1)))) begin
                    step_hit = 1'b1;
                end
            end
        end

        if (s_onehot) begin
            glitch_nxt = '0;
        end else if (glitch_cnt == GLITCH_MAX) begin
            glitch_nxt = glitch_cnt;
        end else begin
            glitch_nxt = glitch_cnt + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                s_cnt[i] <= 4'd0;
                p_cnt[i] <= 4'd0;
            end
            s_led       <= 4'd0;
            p_led       <= 4'd0;
            prev_vld    <= 1'b0;
            scan_cnt    <= '0;
            digit       <= 2'd0;
            glitch_cnt  <= '0;
            an          <= 4'b1111;
            seg         <= 7'h00;
            dp          <= 1'b0;
            active_lane <= 2'd0;
            active_vld  <= 1'b0;
            handoff_cnt <= 8'd0;
            onehot_err  <= 1'b0;
            step_err    <= 1'b0;
        end else begin
            s_cnt[0] <= count1;
            s_cnt[1] <= count2;
            s_cnt[2] <= count3;
            s_cnt[3] <= count4;
            s_led    <= {led4, led3, led2, led1};
            for (int i = 0; i < 4; i++) begin
                p_cnt[i] <= s_cnt[i];
            end
            p_led    <= s_led;
            prev_vld <= 1'b1;

            // Display scan: the digit register advances on scan wrap, the
            // outputs show the digit selected before the advance.
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                digit    <= digit + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            an  <= ~(4'b0001 << digit);
            seg <= hex7(s_cnt[digit]);
            dp  <= s_led[digit];

            if (s_onehot) begin
                active_vld  <= 1'b1;
                active_lane <= s_lane;
            end else begin
                active_vld  <= 1'b0;
            end

            // clr takes priority over any simultaneous set or increment
            if (clr) begin
                glitch_cnt  <= '0;
                handoff_cnt <= 8'd0;
                onehot_err  <= 1'b0;
                step_err    <= 1'b0;
            end else begin
                glitch_cnt <= glitch_nxt;
                if (glitch_nxt == GLITCH_MAX) begin
                    onehot_err <= 1'b1;
                end
                if (step_hit) begin
                    step_err <= 1'b1;
                end
                if (handoff_hit && (handoff_cnt != 8'hFF)) begin
                    handoff_cnt <= handoff_cnt + 8'd1;
                end
            end
        end
    end

endmodule
